stack_sequencer: RTL and testbench

- Multi-cycle executor for the stack-class instructions that the control unit flags through StackOp: PUSH, POP, CALL and RET.
- Owns the stack pointer (SP) and drives a req/ack data-memory port.
- Returns to the datapath:
  - pop data and register-write strobe for POP;
  - PC-load requests for CALL and RET;
  - the live SP, which LDSP/STSP address calculation uses.
- Sits between the decode stage and the data-memory arbiter; the datapath stalls on busy.

---
 rtl/stack_sequencer_pkg.sv | 31 +++
 rtl/stack_sequencer_if.sv | 42 ++++
 rtl/stack_sequencer_sp_counter.sv | 31 +++
 rtl/stack_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_stack_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_sequencer_pkg.sv
// Shared encodings for the stack sequencer: StackOp codes (also imported by
// the control unit) and the sequencer FSM states.
package stack_pkg;

  typedef enum logic [2:0] {
    STK_NONE = 3'b000,
    STK_PUSH = 3'b001,
    STK_POP  = 3'b010,
    STK_CALL = 3'b011,
    STK_RET  = 3'b100
  } stack_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  // True for the four codes the sequencer executes; everything else is reserved.
  function automatic logic is_stack_op(input logic [2:0] code);
    return (code == STK_PUSH) || (code == STK_POP) ||
           (code == STK_CALL) || (code == STK_RET);
  endfunction

  // PUSH and CALL write to the stack; POP and RET read from it.
  function automatic logic is_write_op(input logic [2:0] code);
    return (code == STK_PUSH) || (code == STK_CALL);
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Datapath and data-memory signals of the stack sequencer. The slave modport
// is the sequencer's view; the master modport is the datapath/memory side.
interface stack_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);

  logic              op_valid;
  logic [2:0]        stack_op;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] ret_addr;
  logic [DATA_W-1:0] call_target;
  logic              busy;
  logic              op_done;
  logic              reg_wr;
  logic [DATA_W-1:0] pop_data;
  logic              pc_load;
  logic [DATA_W-1:0] pc_next;
  logic [ADDR_W-1:0] sp;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stack_fault;

  modport slave (
    input  op_valid, stack_op, push_data, ret_addr, call_target,
    input  mem_rdata, mem_ack,
    output busy, op_done, reg_wr, pop_data, pc_load, pc_next, sp,
    output mem_req, mem_we, mem_addr, mem_wdata, stack_fault
  );

  modport master (
    output op_valid, stack_op, push_data, ret_addr, call_target,
    output mem_rdata, mem_ack,
    input  busy, op_done, reg_wr, pop_data, pc_load, pc_next, sp,
    input  mem_req, mem_we, mem_addr, mem_wdata, stack_fault
  );

endinterface

// File: rtl/stack_sequencer_sp_counter.sv
// Stack pointer register: resets to the empty position, moves by one word on
// inc/dec, and reports full/empty for the optional bounds check.
module sp_counter #(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] STACK_TOP  = 10'd1023,
  parameter logic [ADDR_W-1:0] STACK_BASE = 10'd1016
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              empty
);

  // SP register; arithmetic wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= STACK_TOP;
    end else if (inc && !dec) begin
      sp <= sp + ADDR_W'(1);
    end else if (dec && !inc) begin
      sp <= sp - ADDR_W'(1);
    end
  end

  assign full  = (sp == STACK_BASE);
  assign empty = (sp == STACK_TOP);

endmodule

// File: rtl/stack_sequencer.sv
// Multi-cycle executor for PUSH/POP/CALL/RET. Owns SP, drives a req/ack data
// memory port and returns pop data / PC loads to the datapath.
// Optional build macro: STACK_BOUNDS_CHECK_EN (overflow/underflow trapping).
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] STACK_TOP  = 10'd1023,
  parameter logic [ADDR_W-1:0] STACK_BASE = 10'd1016
) (
  input logic              clk,
  input logic              rst,
  stack_sequencer_if.slave bus
);

`ifdef STACK_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  seq_state_t        state;
  seq_state_t        state_nxt;
  stack_op_t         op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] target_q;
  logic [DATA_W-1:0] pop_q;
  logic              skip_q;
  logic              sticky_q;

  logic              accept;
  logic              bound_hit;
  logic              sp_inc;
  logic              sp_dec;
  logic [ADDR_W-1:0] sp_val;
  logic              sp_full;
  logic              sp_empty;

  sp_counter #(
    .ADDR_W     (ADDR_W),
    .STACK_TOP  (STACK_TOP),
    .STACK_BASE (STACK_BASE)
  ) u_sp (
    .clk   (clk),
    .rst   (rst),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .sp    (sp_val),
    .full  (sp_full),
    .empty (sp_empty)
  );

  // A new op is only taken in IDLE; requests while busy are ignored and the
  // datapath keeps holding the instruction.
  assign accept    = (state == ST_IDLE) && bus.op_valid && is_stack_op(bus.stack_op);
  assign bound_hit = BOUNDS_EN &&
                     (is_write_op(bus.stack_op) ? sp_full : sp_empty);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the op and its operands at accept so the memory phase sees stable values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= STK_NONE;
      wdata_q  <= '0;
      target_q <= '0;
      skip_q   <= 1'b0;
    end else if (accept) begin
      op_q     <= stack_op_t'(bus.stack_op);
      wdata_q  <= (bus.stack_op == STK_CALL) ? bus.ret_addr : bus.push_data;
      target_q <= bus.call_target;
      skip_q   <= bound_hit;
    end
  end

  // Popped word is captured on the read ack and held until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_q <= '0;
    end else if ((state == ST_RD) && bus.mem_ack) begin
      pop_q <= bus.mem_rdata;
    end
  end

  // Sticky fault flag; only ever set when bounds checking is compiled in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (accept && bound_hit) begin
      sticky_q <= 1'b1;
    end
  end

  // Next-state and SP control; SP moves only on the memory ack.
  always_comb begin
    state_nxt = state;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bound_hit) begin
            state_nxt = ST_DONE;
          end else if (is_write_op(bus.stack_op)) begin
            state_nxt = ST_WR;
          end else begin
            state_nxt = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (bus.mem_ack) begin
          sp_dec    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_RD: begin
        if (bus.mem_ack) begin
          sp_inc    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Memory port and completion strobes, decoded from the current state.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.op_done   = 1'b0;
    bus.reg_wr    = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_next   = '0;
    case (state)
      ST_WR: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = sp_val - ADDR_W'(1);
        bus.mem_wdata = wdata_q;
      end
      ST_RD: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = sp_val;
      end
      ST_DONE: begin
        bus.op_done = 1'b1;
        if (!skip_q) begin
          bus.reg_wr  = (op_q == STK_POP);
          bus.pc_load = (op_q == STK_CALL) || (op_q == STK_RET);
          if (op_q == STK_CALL) begin
            bus.pc_next = target_q;
          end else if (op_q == STK_RET) begin
            bus.pc_next = pop_q;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.sp          = sp_val;
  assign bus.pop_data    = pop_q;
  assign bus.stack_fault = sticky_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed self-checking bench for stack_sequencer. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
module tb_stack_sequencer;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  stack_sequencer_if #(.DATA_W(32), .ADDR_W(10)) bus ();

  stack_sequencer #(
    .DATA_W     (32),
    .ADDR_W     (10),
    .STACK_TOP  (10'd1023),
    .STACK_BASE (10'd1016)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [2:0] op,
                                input logic [31:0] pdata, input logic [31:0] raddr,
                                input logic [31:0] target);
    bus.op_valid    = valid;
    bus.stack_op    = op;
    bus.push_data   = pdata;
    bus.ret_addr    = raddr;
    bus.call_target = target;
  endtask

  task automatic set_mem(input logic ack, input logic [31:0] rdata);
    bus.mem_ack   = ack;
    bus.mem_rdata = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    set_mem(1'b0, 32'h0);
    repeat (2) @(negedge clk);

    // Reset state (checked while rst is still high).
    check_output("rst_busy",     32'(bus.busy), 32'd0);
    check_output("rst_sp",       32'(bus.sp), 32'd1023);
    check_output("rst_mem_req",  32'(bus.mem_req), 32'd0);
    check_output("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_output("rst_pop_data", bus.pop_data, 32'd0);
    check_output("rst_pc_next",  bus.pc_next, 32'd0);
    check_output("rst_fault",    32'(bus.stack_fault), 32'd0);
    rst = 1'b0;
    next_cycle();

    // 1: PUSH DEADBEEF, ack in the request cycle.
    $display("[TB] step 1 PUSH");
    apply_stimulus(1'b1, STK_PUSH, 32'hDEADBEEF, 32'h0, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    check_output("push_req",   32'(bus.mem_req), 32'd1);
    check_output("push_we",    32'(bus.mem_we), 32'd1);
    check_output("push_addr",  32'(bus.mem_addr), 32'd1022);
    check_output("push_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check_output("push_sp_pending", 32'(bus.sp), 32'd1023);
    set_mem(1'b1, 32'h0);
    next_cycle();
    set_mem(1'b0, 32'h0);
    check_output("push_done",   32'(bus.op_done), 32'd1);
    check_output("push_reg_wr", 32'(bus.reg_wr), 32'd0);
    check_output("push_req_off",32'(bus.mem_req), 32'd0);
    check_output("push_sp",     32'(bus.sp), 32'd1022);
    next_cycle();
    check_output("push_idle",   32'(bus.busy), 32'd0);

    // 2: POP with the ack delayed three cycles.
    $display("[TB] step 2 POP");
    apply_stimulus(1'b1, STK_POP, 32'h0, 32'h0, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    check_output("pop_we", 32'(bus.mem_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_output("pop_wait_req",  32'(bus.mem_req), 32'd1);
      check_output("pop_wait_addr", 32'(bus.mem_addr), 32'd1022);
      check_output("pop_wait_busy", 32'(bus.busy), 32'd1);
      check_output("pop_wait_sp",   32'(bus.sp), 32'd1022);
      next_cycle();
    end
    check_output("pop_ack_addr", 32'(bus.mem_addr), 32'd1022);
    set_mem(1'b1, 32'hDEADBEEF);
    next_cycle();
    set_mem(1'b0, 32'h0);
    check_output("pop_done",   32'(bus.op_done), 32'd1);
    check_output("pop_reg_wr", 32'(bus.reg_wr), 32'd1);
    check_output("pop_pc_load",32'(bus.pc_load), 32'd0);
    check_output("pop_data",   bus.pop_data, 32'hDEADBEEF);
    check_output("pop_sp",     32'(bus.sp), 32'd1023);
    next_cycle();
    check_output("pop_hold",   bus.pop_data, 32'hDEADBEEF);

    // 3: CALL then RET.
    $display("[TB] step 3 CALL/RET");
    apply_stimulus(1'b1, STK_CALL, 32'h0, 32'h40, 32'h100);
    next_cycle();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    check_output("call_addr",  32'(bus.mem_addr), 32'd1022);
    check_output("call_wdata", bus.mem_wdata, 32'h40);
    check_output("call_we",    32'(bus.mem_we), 32'd1);
    set_mem(1'b1, 32'h0);
    next_cycle();
    set_mem(1'b0, 32'h0);
    check_output("call_pc_load", 32'(bus.pc_load), 32'd1);
    check_output("call_pc_next", bus.pc_next, 32'h100);
    check_output("call_reg_wr",  32'(bus.reg_wr), 32'd0);
    check_output("call_sp",      32'(bus.sp), 32'd1022);
    next_cycle();
    apply_stimulus(1'b1, STK_RET, 32'h0, 32'h0, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    check_output("ret_addr", 32'(bus.mem_addr), 32'd1022);
    check_output("ret_we",   32'(bus.mem_we), 32'd0);
    set_mem(1'b1, 32'h40);
    next_cycle();
    set_mem(1'b0, 32'h0);
    check_output("ret_pc_load", 32'(bus.pc_load), 32'd1);
    check_output("ret_pc_next", bus.pc_next, 32'h40);
    check_output("ret_reg_wr",  32'(bus.reg_wr), 32'd0);
    check_output("ret_sp",      32'(bus.sp), 32'd1023);
    next_cycle();

    // 4: reserved codes and an op offered while busy.
    $display("[TB] step 4 reserved/busy");
    apply_stimulus(1'b1, 3'b000, 32'h77, 32'h0, 32'h0);
    next_cycle();
    check_output("rsv0_busy", 32'(bus.busy), 32'd0);
    check_output("rsv0_req",  32'(bus.mem_req), 32'd0);
    apply_stimulus(1'b1, 3'b111, 32'h77, 32'h0, 32'h0);
    next_cycle();
    check_output("rsv7_busy", 32'(bus.busy), 32'd0);
    check_output("rsv7_req",  32'(bus.mem_req), 32'd0);
    check_output("rsv7_sp",   32'(bus.sp), 32'd1023);
    apply_stimulus(1'b1, STK_PUSH, 32'h11, 32'h0, 32'h0);
    next_cycle();
    apply_stimulus(1'b1, STK_PUSH, 32'h22, 32'h0, 32'h0);
    next_cycle();
    check_output("busy_push_wdata", bus.mem_wdata, 32'h11);
    check_output("busy_push_addr",  32'(bus.mem_addr), 32'd1022);
    set_mem(1'b1, 32'h0);
    next_cycle();
    set_mem(1'b0, 32'h0);
    check_output("busy_push_done", 32'(bus.op_done), 32'd1);
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    next_cycle();
    check_output("busy_push_sp",   32'(bus.sp), 32'd1022);
    check_output("busy_push_idle", 32'(bus.busy), 32'd0);

    // 5: asynchronous reset in the middle of a write.
    $display("[TB] step 5 reset mid-WR");
    apply_stimulus(1'b1, STK_PUSH, 32'h33, 32'h0, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    check_output("mid_req_before", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("mid_req_after",  32'(bus.mem_req), 32'd0);
    check_output("mid_busy_after", 32'(bus.busy), 32'd0);
    check_output("mid_sp_after",   32'(bus.sp), 32'd1023);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    check_output("mid_no_done", 32'(bus.op_done), 32'd0);
    check_output("mid_idle",    32'(bus.busy), 32'd0);

    // 6: underflow/overflow behaviour depends on the build.
`ifdef STACK_BOUNDS_CHECK_EN
    $display("[TB] step 6 bounds check enabled");
    apply_stimulus(1'b1, STK_POP, 32'h0, 32'h0, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    check_output("uf_req",    32'(bus.mem_req), 32'd0);
    check_output("uf_done",   32'(bus.op_done), 32'd1);
    check_output("uf_reg_wr", 32'(bus.reg_wr), 32'd0);
    check_output("uf_fault",  32'(bus.stack_fault), 32'd1);
    check_output("uf_sp",     32'(bus.sp), 32'd1023);
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, STK_PUSH, 32'(i), 32'h0, 32'h0);
      next_cycle();
      apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      check_output("fill_addr", 32'(bus.mem_addr), 32'(1022 - i));
      set_mem(1'b1, 32'h0);
      next_cycle();
      set_mem(1'b0, 32'h0);
      next_cycle();
    end
    check_output("full_sp", 32'(bus.sp), 32'd1016);
    apply_stimulus(1'b1, STK_PUSH, 32'h99, 32'h0, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    check_output("of_req",   32'(bus.mem_req), 32'd0);
    check_output("of_done",  32'(bus.op_done), 32'd1);
    check_output("of_sp",    32'(bus.sp), 32'd1016);
    check_output("of_fault", 32'(bus.stack_fault), 32'd1);
    next_cycle();
`else
    $display("[TB] step 6 bounds check disabled");
    apply_stimulus(1'b1, STK_POP, 32'h0, 32'h0, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    check_output("wrap_req",  32'(bus.mem_req), 32'd1);
    check_output("wrap_addr", 32'(bus.mem_addr), 32'd1023);
    set_mem(1'b1, 32'h55);
    next_cycle();
    set_mem(1'b0, 32'h0);
    check_output("wrap_sp",     32'(bus.sp), 32'd0);
    check_output("wrap_reg_wr", 32'(bus.reg_wr), 32'd1);
    check_output("wrap_pop",    bus.pop_data, 32'h55);
    check_output("wrap_fault",  32'(bus.stack_fault), 32'd0);
    next_cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
